cmp_arb: RTL and testbench

//  Arbitrates one shared 32-bit comparator (comp32bs) between two requesters:
//  req0 = branch unit (BEQ..BGEU), req1 = ALU set-less-than path (SLT/SLTU).

---
 rtl/cmp_arb_pkg.sv | 34 +++
 rtl/comp32bs.sv | 24 ++
 rtl/cmp_arb.sv | 157 +++++++++++++++
 tb/tb_cmp_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_arb_pkg
//  Description : Shared compare op codes, FSM state codes and the latched
//                transaction record for the comparator arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_arb_pkg;

    // funct3 compare op codes; all eight codes carry a defined meaning
    localparam logic [2:0] CMP_EQ   = 3'b000;
    localparam logic [2:0] CMP_NE   = 3'b001;
    localparam logic [2:0] CMP_SLT  = 3'b010;
    localparam logic [2:0] CMP_SLTU = 3'b011;
    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_GE   = 3'b101;
    localparam logic [2:0] CMP_LTU  = 3'b110;
    localparam logic [2:0] CMP_GEU  = 3'b111;

    // Arbiter FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CMP   = 2'b01;
    localparam logic [1:0] ST_RESP  = 2'b10;

    // Everything captured from the winning requester at the handshake
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        id;
    } cmp_txn_t;

endpackage : cmp_arb_pkg
`default_nettype wire

// File: rtl/comp32bs.sv
`default_nettype none
// ============================================================================
//  Module      : comp32bs
//  Description : 32-bit magnitude comparator producing signed greater-than,
//                equality and unsigned greater-than flags.
//  Revision    : 1.0  initial release
// ============================================================================
module comp32bs (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_gts,
    output logic        o_eq,
    output logic        o_gtu
);

    // Pure combinational flags; the consumer decides which ones matter
    always_comb begin
        o_eq  = (i_a == i_b);
        o_gtu = (i_a > i_b);
        o_gts = ($signed(i_a) > $signed(i_b));
    end

endmodule : comp32bs
`default_nettype wire

// File: rtl/cmp_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_arb
//  Description : Shares one comp32bs comparator between the branch unit
//                (req0) and the SLT/SLTU path (req1). One compare in flight;
//                result returned on a shared, id-tagged response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_arb
    import cmp_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_res,
    output logic        rsp_id,
    output logic        busy
);

    logic [1:0] state_q, state_d;
    cmp_txn_t   txn_q, txn_d;
    logic       last_q, last_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_res_q, rsp_res_d;
    logic       rsp_id_q, rsp_id_d;

    logic       w_win_id;
    logic       w_can_grant;
    logic       w_hs;
    logic       w_gts;
    logic       w_eq;
    logic       w_gtu;
    logic       w_res;

    // Winner selection: round-robin picks the requester that did not win last
    generate
        if (RR_EN) begin : g_rr
            assign w_win_id = (req0_valid & req1_valid) ? ~last_q : ~req0_valid;
        end else begin : g_fixed
            assign w_win_id = ~req0_valid;
        end
    endgenerate

    // Grants only from IDLE, never while flushing or held in reset
    assign w_can_grant = rst_n & (state_q == ST_IDLE) & ~flush;
    assign req0_ready  = w_can_grant & req0_valid & ~w_win_id;
    assign req1_ready  = w_can_grant & req1_valid &  w_win_id;
    assign w_hs        = req0_ready | req1_ready;

    // Comparator sees only the latched operands, never the live request ports
    comp32bs u_comp (
        .i_a   (txn_q.a),
        .i_b   (txn_q.b),
        .o_gts (w_gts),
        .o_eq  (w_eq),
        .o_gtu (w_gtu)
    );

    // Op decode: map the comparator flags onto the requested relation
    always_comb begin
        w_res = 1'b0;
        case (txn_q.op)
            CMP_EQ:            w_res =  w_eq;
            CMP_NE:            w_res = ~w_eq;
            CMP_SLT, CMP_LT:   w_res = ~w_gts & ~w_eq;
            CMP_GE:            w_res =  w_gts |  w_eq;
            CMP_SLTU, CMP_LTU: w_res = ~w_gtu & ~w_eq;
            CMP_GEU:           w_res =  w_gtu |  w_eq;
            default:           w_res = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE -> CMP -> RESP sequence
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (w_hs) begin
                    txn_d.id = w_win_id;
                    txn_d.op = w_win_id ? req1_op : req0_op;
                    txn_d.a  = w_win_id ? req1_a  : req0_a;
                    txn_d.b  = w_win_id ? req1_b  : req0_b;
                    if (RR_EN) begin
                        last_d = w_win_id;
                    end
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_res_d   = w_res;
                    rsp_id_d    = txn_q.id;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // A transfer accepted together with flush is still delivered
                if (rsp_ready || flush) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves the pointer at 1 so req0 wins first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            txn_q       <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : cmp_arb
`default_nettype wire

// File: tb/tb_cmp_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_arb
//  Description : Self-checking bench for cmp_arb (round-robin instance plus a
//                fixed-priority instance fed with the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;

    logic req0_ready, req1_ready, rsp_valid, rsp_res, rsp_id, busy;
    logic fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_res, fp_rsp_id, fp_busy;

    int   checks = 0;
    int   errors = 0;
    bit   model_last;

    always #5 clk = ~clk;

    cmp_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
        .rsp_id(rsp_id), .busy(busy)
    );

    cmp_arb #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(fp_rsp_res),
        .rsp_id(fp_rsp_id), .busy(fp_busy)
    );

    // Reference relation for each funct3 code
    function automatic bit exp_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:       return a == b;
            3'd1:       return a != b;
            3'd2, 3'd4: return $signed(a) <  $signed(b);
            3'd5:       return $signed(a) >= $signed(b);
            3'd3, 3'd6: return a < b;
            default:    return a >= b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    task automatic scramble();
        req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom;
        req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom;
    endtask

    // Waits (bounded) at falling edges until the given requester is granted
    task automatic wait_ready(input bit id, output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // One complete transaction from a single requester with rsp_ready held high
    task automatic run_txn(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got;
        bit e;
        e = exp_res(op, a, b);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1; flush = 1'b0;
        set_req(id, op, a, b);
        wait_ready(id, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_grant_timeout: id %0d never granted", id);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        checks++;
        if ((id ? fp_req1_ready : fp_req0_ready) !== 1'b1) begin
            errors++;
            $display("FAIL txn_fp_grant: fixed-priority instance did not grant id %0d", id);
        end
        step();
        model_last = id;
        req0_valid = 1'b0; req1_valid = 1'b0;
        scramble();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL txn_cmp_state: rsp_valid=%b busy=%b, required 0 and 1", rsp_valid, busy);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== e || rsp_id !== id) begin
            errors++;
            $display("FAIL txn_result: op=%0d a=%h b=%h got valid=%b res=%b id=%b, required 1 %b %b",
                     op, a, b, rsp_valid, rsp_res, rsp_id, e, id);
        end
        checks++;
        if (fp_rsp_valid !== 1'b1 || fp_rsp_res !== e) begin
            errors++;
            $display("FAIL txn_fp_result: got valid=%b res=%b, required 1 %b", fp_rsp_valid, fp_rsp_res, e);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL txn_return_idle: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        bit got;
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, 3'd0, 32'd3, 32'd3);
        set_req(1'b1, 3'd3, 32'd1, 32'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0
            || rsp_res !== 1'b0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b%b rsp_valid=%b busy=%b res=%b id=%b, required all 0",
                     req0_ready, req1_ready, rsp_valid, busy, rsp_res, rsp_id);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last = 1'b1;
        wait_ready(1'b0, got);
        checks++;
        if (!got || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        step();
        model_last = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 1'b1 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_rsp: valid=%b res=%b id=%b, required 1 1 0", rsp_valid, rsp_res, rsp_id);
        end
        step();
    endtask

    task automatic test_signed_unsigned();
        run_txn(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1);
        run_txn(1'b1, 3'b011, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_all_ops();
        for (int op = 0; op < 8; op++)
            run_txn(1'($urandom), 3'(op), 32'h8000_0000, 32'h8000_0000);
        run_txn(1'b0, 3'b100, 32'd5, 32'd7);
        run_txn(1'b0, 3'b111, 32'd5, 32'd7);
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_txn(1'($urandom), 3'($urandom), a, b);
        end
    endtask

    task automatic test_round_robin();
        bit q_res[$];
        bit q_id[$];
        int grants = 0;
        bit exp_id;
        flush = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, 3'($urandom), $urandom, $urandom);
        set_req(1'b1, 3'($urandom), $urandom, $urandom);
        for (int cyc = 0; cyc < 40 && (grants < 4 || q_id.size() > 0); cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (q_id.size() == 0) begin
                    errors++;
                    $display("FAIL rr_unexpected_rsp: response with id %b not expected", rsp_id);
                end else begin
                    bit er;
                    bit ei;
                    er = q_res.pop_front();
                    ei = q_id.pop_front();
                    if (rsp_res !== er || rsp_id !== ei) begin
                        errors++;
                        $display("FAIL rr_rsp: got res=%b id=%b, required %b %b", rsp_res, rsp_id, er, ei);
                    end
                end
            end
            if (grants < 4 && (req0_ready === 1'b1 || req1_ready === 1'b1)) begin
                exp_id = ~model_last;
                checks++;
                if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
                    errors++;
                    $display("FAIL rr_grant: got ready0=%b ready1=%b, required winner %0d",
                             req0_ready, req1_ready, exp_id);
                end
                checks++;
                if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fp_grant: got ready0=%b ready1=%b, required 1 0", fp_req0_ready, fp_req1_ready);
                end
                q_res.push_back(exp_id ? exp_res(req1_op, req1_a, req1_b) : exp_res(req0_op, req0_a, req0_b));
                q_id.push_back(exp_id);
                model_last = exp_id;
                grants++;
            end
            step();
            if (grants >= 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (grants != 4 || q_id.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout: grants=%0d pending=%0d, required 4 0", grants, q_id.size());
        end
        step();
    endtask

    task automatic test_backpressure();
        bit got;
        bit e;
        flush = 1'b0; rsp_ready = 1'b0;
        req1_valid = 1'b0;
        set_req(1'b0, 3'b101, 32'hFFFF_FFF0, 32'h0000_0010);
        e = exp_res(3'b101, 32'hFFFF_FFF0, 32'h0000_0010);
        wait_ready(1'b0, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_grant_timeout: req0 never granted");
        end
        step();
        model_last = 1'b0;
        set_req(1'b1, 3'd0, 32'd0, 32'd0);
        scramble();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_res !== e || rsp_id !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b res=%b id=%b ready=%b%b busy=%b, required 1 %b 0 00 1",
                         i, rsp_valid, rsp_res, rsp_id, req0_ready, req1_ready, busy, e);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_flush();
        bit got;
        int delivered;
        bit exp_id;
        // Flush while comparing: nothing comes out
        rsp_ready = 1'b1; flush = 1'b0;
        set_req(1'b0, 3'd0, 32'd1, 32'd1);
        wait_ready(1'b0, got);
        step();
        model_last = 1'b0;
        req0_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cmp: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cmp_late: rsp_valid=%b, required 0", rsp_valid);
        end
        // Flush in RESP together with rsp_ready: exactly one delivery
        set_req(1'b1, 3'd1, 32'd1, 32'd2);
        wait_ready(1'b1, got);
        step();
        model_last = 1'b1;
        req1_valid = 1'b0;
        step();
        flush = 1'b1; rsp_ready = 1'b1;
        delivered = 0;
        @(negedge clk);
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) delivered++;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_idle: busy=%b, required 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) delivered++;
            step();
        end
        checks++;
        if (delivered != 1) begin
            errors++;
            $display("FAIL flush_resp_delivered: got %0d responses, required 1", delivered);
        end
        // Flush in RESP without rsp_ready: response discarded
        set_req(1'b0, 3'd7, 32'd9, 32'd2);
        wait_ready(1'b0, got);
        step();
        model_last = 1'b0;
        req0_valid = 1'b0; rsp_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; rsp_ready = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_drop: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        // Flush in IDLE: no grant and the pointer does not move
        flush = 1'b1;
        set_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd3);
        set_req(1'b1, 3'd6, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_busy: busy=%b, required 0", busy);
        end
        flush = 1'b0;
        exp_id = ~model_last;
        @(negedge clk);
        checks++;
        if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
            errors++;
            $display("FAIL flush_idle_pointer: ready0=%b ready1=%b, required winner %0d",
                     req0_ready, req1_ready, exp_id);
        end
        step();
        model_last = exp_id;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id
            || rsp_res !== (exp_id ? exp_res(3'd6, 32'hFFFF_FFFE, 32'd3) : exp_res(3'd2, 32'hFFFF_FFFE, 32'd3))) begin
            errors++;
            $display("FAIL flush_idle_rsp: valid=%b res=%b id=%b", rsp_valid, rsp_res, rsp_id);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        model_last = 1'b1;
        test_reset();
        test_signed_unsigned();
        test_all_ops();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cmp_arb
`default_nettype wire
